zueira_int_ctrl: RTL and testbench

Parametrised multi-channel interrupt controller for the ZueiraI core family, replacing the single `flags_INTERRUPT` line and the two-cycle vector fetch from memory. Latches rising edges on `NUM_CH` request lines, masks and prioritises them, and presents one request with a ready-made vector address and page. The core answers with an ack on ISR entry and an end-of-interrupt (EOI) on RETI. An optional build mode allows higher-priority channels to preempt a running ISR.

---
 rtl/zueira_pkg.sv | 13 +
 rtl/zueira_prio_enc.sv | 20 ++
 rtl/zueira_int_ctrl.sv | 143 ++++++++++++++
 tb/tb_zueira_int_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zueira_pkg.sv
// Shared ZueiraI interrupt types and default vector-table placement, also used by the core.
package zueira_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam int unsigned ZUEIRA_VEC_BASE = 32'hE0;
  localparam int unsigned ZUEIRA_INT_PAGE = 0;

endpackage

// File: rtl/zueira_prio_enc.sv
// Lowest-index find-first-set; index 0 is the highest priority.
module zueira_prio_enc #(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_CH-1:0] req,
  output logic              valid,
  output logic [IDX_W-1:0]  idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set index is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/zueira_int_ctrl.sv
// Multi-channel edge-latched interrupt controller for the ZueiraI core.
// Define ZUEIRA_INT_NESTING_EN to let higher-priority channels preempt a running ISR.
module zueira_int_ctrl
  import zueira_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned VEC_W       = 8,
  parameter int unsigned PAGE_W      = 2,
  parameter int unsigned VEC_BASE    = ZUEIRA_VEC_BASE,
  parameter int unsigned STRIDE_LOG2 = 1,
  parameter int unsigned INT_PAGE    = ZUEIRA_INT_PAGE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] irq_i,
  input  logic              gie,
  input  logic              mask_we,
  input  logic [NUM_CH-1:0] mask_wdata,
  output logic              int_req,
  output logic [VEC_W-1:0]  int_vec,
  output logic [PAGE_W-1:0] int_page,
  input  logic              int_ack,
  input  logic              int_eoi,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] in_service,
  output logic              nest_err
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  int_state_t        state_q, state_d;
  logic [NUM_CH-1:0] irq_q;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] in_service_q, in_service_d;
  logic [IDX_W-1:0]  ch_q, ch_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic              nest_err_q, nest_err_d;

  logic              cand_valid, svc_valid, load;
  logic [IDX_W-1:0]  cand_idx, svc_idx;
  logic [NUM_CH-1:0] ch_oh, svc_top_oh, pend_clr;

  zueira_prio_enc #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_cand (
    .req   (pending_q & mask_q),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  zueira_prio_enc #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_svc (
    .req   (in_service_q),
    .valid (svc_valid),
    .idx   (svc_idx)
  );

  assign ch_oh      = NUM_CH'(1) << ch_q;
  assign svc_top_oh = NUM_CH'(svc_valid) << svc_idx;

  always_comb begin
    state_d      = state_q;
    in_service_d = in_service_q;
    pend_clr     = '0;
    load         = 1'b0;
    nest_err_d   = nest_err_q | (int_eoi && (in_service_q == '0));
    case (state_q)
      IDLE: begin
        if (gie && cand_valid) begin
          state_d = REQ;
          load    = 1'b1;
        end
      end
      REQ: begin
`ifdef ZUEIRA_INT_NESTING_EN
        if (int_eoi) in_service_d = in_service_d & ~svc_top_oh;
`endif
        // A request is never withdrawn: only the ack moves us on.
        if (int_ack) begin
          pend_clr     = ch_oh;
          in_service_d = in_service_d | ch_oh;
          state_d      = SERVICE;
        end
      end
      SERVICE: begin
        if (int_eoi) begin
          in_service_d = in_service_q & ~svc_top_oh;
          if (in_service_d == '0) state_d = IDLE;
        end
`ifdef ZUEIRA_INT_NESTING_EN
        else if (gie && cand_valid && (cand_idx < svc_idx)) begin
          state_d = REQ;
          load    = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    ch_d   = ch_q;
    vec_d  = vec_q;
    page_d = page_q;
    if (load) begin
      ch_d   = cand_idx;
      vec_d  = VEC_W'(VEC_BASE) + (VEC_W'(cand_idx) << STRIDE_LOG2);
      page_d = PAGE_W'(INT_PAGE);
    end

    // A fresh edge wins over the ack clearing the same bit.
    pending_d = (pending_q & ~pend_clr) | (irq_i & ~irq_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      irq_q        <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      in_service_q <= '0;
      ch_q         <= '0;
      vec_q        <= '0;
      page_q       <= '0;
      nest_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_q        <= irq_i;
      pending_q    <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
      in_service_q <= in_service_d;
      ch_q         <= ch_d;
      vec_q        <= vec_d;
      page_q       <= page_d;
      nest_err_q   <= nest_err_d;
    end
  end

  assign int_req    = (state_q == REQ);
  assign int_vec    = vec_q;
  assign int_page   = page_q;
  assign pending    = pending_q;
  assign in_service = in_service_q;
  assign nest_err   = nest_err_q;

endmodule

// File: tb/tb_zueira_int_ctrl.sv
// Directed plus randomized bench for zueira_int_ctrl against a bit-set reference model.
module tb_zueira_int_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_i;
  logic       gie;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic       int_req;
  logic [7:0] int_vec;
  logic [1:0] int_page;
  logic       int_ack;
  logic       int_eoi;
  logic [7:0] pending;
  logic [7:0] in_service;
  logic       nest_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: request bookkeeping as plain bit sets plus the requested channel.
  logic [7:0] m_pend, m_mask, m_prev, m_svc;
  int         m_req_ch;
  int         m_vec;
  logic       m_err;

  always #5 clk = ~clk;

  zueira_int_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .irq_i      (irq_i),
    .gie        (gie),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_req    (int_req),
    .int_vec    (int_vec),
    .int_page   (int_page),
    .int_ack    (int_ack),
    .int_eoi    (int_eoi),
    .pending    (pending),
    .in_service (in_service),
    .nest_err   (nest_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_pend = '0; m_mask = '0; m_prev = '0; m_svc = '0;
    m_req_ch = -1; m_vec = 0; m_err = 1'b0;
  endtask

  task automatic step();
    int cand, top;
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      cand = lowest(m_pend & m_mask);
      top  = lowest(m_svc);
      if (int_eoi && m_svc == 0) m_err = 1'b1;
      if (m_req_ch >= 0) begin
`ifdef ZUEIRA_INT_NESTING_EN
        if (int_eoi && top >= 0) m_svc[top] = 1'b0;
`endif
        if (int_ack) begin
          m_pend[m_req_ch] = 1'b0;
          m_svc[m_req_ch]  = 1'b1;
          m_req_ch = -1;
        end
      end else if (m_svc != 0) begin
        if (int_eoi) m_svc[top] = 1'b0;
`ifdef ZUEIRA_INT_NESTING_EN
        else if (gie && cand >= 0 && cand < top) begin
          m_req_ch = cand;
          m_vec = (224 + cand * 2) % 256;
        end
`endif
      end else if (gie && cand >= 0) begin
        m_req_ch = cand;
        m_vec = (224 + cand * 2) % 256;
      end
      m_pend = m_pend | (irq_i & ~m_prev);
      if (mask_we) m_mask = mask_wdata;
      m_prev = irq_i;
    end
    #1;
    check("int_req", 32'(int_req), 32'(m_req_ch >= 0));
    if (m_req_ch >= 0) begin
      check("int_vec", 32'(int_vec), 32'(m_vec));
      check("int_page", 32'(int_page), 32'd0);
    end
    check("pending", 32'(pending), 32'(m_pend));
    check("in_service", 32'(in_service), 32'(m_svc));
    check("nest_err", 32'(nest_err), 32'(m_err));
  endtask

  task automatic write_mask(input logic [7:0] m);
    mask_we = 1'b1; mask_wdata = m;
    step();
    mask_we = 1'b0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; step(); int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    int_eoi = 1'b1; step(); int_eoi = 1'b0;
  endtask

  initial begin
    irq_i = '0; gie = 1'b1; mask_we = 1'b0; mask_wdata = '0;
    int_ack = 1'b0; int_eoi = 1'b0; rst = 1'b0;
    model_clear();
    step(); step();
    check("rst_int_req", 32'(int_req), 32'd0);
    check("rst_int_vec", 32'(int_vec), 32'd0);
    rst = 1'b1;

    // Single channel 3, held high: one request only.
    write_mask(8'hFF);
    irq_i = 8'h08; step();
    check("t1_no_req_yet", 32'(int_req), 32'd0);
    step();
    check("t1_req", 32'(int_req), 32'd1);
    check("t1_vec", 32'(int_vec), 32'hE6);
    pulse_ack();
    check("t1_svc", 32'(in_service), 32'h08);
    step(); step();
    pulse_eoi();
    check("t1_svc_clr", 32'(in_service), 32'h00);
    step();
    irq_i = 8'h00; step();
    $display("test1 channel3 single request done");

    // Two simultaneous edges: ch1 first, then ch5.
    irq_i = 8'h22; step();
    check("t2_pend", 32'(pending), 32'h22);
    irq_i = 8'h00; step();
    check("t2_vec1", 32'(int_vec), 32'hE2);
    pulse_ack();
    check("t2_pend_after_ack", 32'(pending), 32'h20);
    pulse_eoi();
    step();
    check("t2_vec2", 32'(int_vec), 32'hEA);
    pulse_ack();
    check("t2_pend_empty", 32'(pending), 32'h00);
    pulse_eoi();
    $display("test2 priority ordering done");

    // Masked channel 0 released by a later mask write.
    write_mask(8'hFE);
    irq_i = 8'h01; step();
    irq_i = 8'h00; step(); step(); step();
    check("t3_masked", 32'(int_req), 32'd0);
    write_mask(8'h01);
    step();
    check("t3_req", 32'(int_req), 32'd1);
    check("t3_vec", 32'(int_vec), 32'hE0);
    pulse_ack();
    pulse_eoi();
    $display("test3 mask release done");

    // ch4 in service, ch2 arrives.
    write_mask(8'hFF);
    irq_i = 8'h10; step();
    irq_i = 8'h00; step();
    pulse_ack();
    check("t4_svc4", 32'(in_service), 32'h10);
    irq_i = 8'h04; step();
    irq_i = 8'h00; step();
`ifdef ZUEIRA_INT_NESTING_EN
    check("t4_nest_req", 32'(int_req), 32'd1);
    check("t4_nest_vec", 32'(int_vec), 32'hE4);
    pulse_ack();
    check("t4_nest_svc", 32'(in_service), 32'h14);
    pulse_eoi();
    pulse_eoi();
`else
    step();
    check("t4_no_preempt", 32'(int_req), 32'd0);
    pulse_eoi();
    step();
    check("t4_req_after_eoi", 32'(int_req), 32'd1);
    check("t4_vec", 32'(int_vec), 32'hE4);
    pulse_ack();
    pulse_eoi();
`endif
    $display("test4 ch2 vs in-service ch4 done");

    // Spurious EOI is sticky.
    pulse_eoi();
    check("t5_nest_err", 32'(nest_err), 32'd1);
    step(); step();
    check("t5_nest_err_sticky", 32'(nest_err), 32'd1);

    // Reset in the middle of a request.
    irq_i = 8'h01; step();
    irq_i = 8'h00; step();
    check("t6_in_req", 32'(int_req), 32'd1);
    rst = 1'b0; step();
    check("t6_req0", 32'(int_req), 32'd0);
    check("t6_vec0", 32'(int_vec), 32'd0);
    check("t6_page0", 32'(int_page), 32'd0);
    check("t6_pend0", 32'(pending), 32'd0);
    check("t6_err0", 32'(nest_err), 32'd0);
    rst = 1'b1;
    $display("test5/6 nest_err and reset done");

    // Randomized traffic.
    write_mask(8'hFF);
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) irq_i[b] = ~irq_i[b];
      gie     = ($urandom_range(0, 7) != 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_wdata = 8'($urandom);
      int_ack = (m_req_ch >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      int_eoi = (m_svc != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      rst     = ($urandom_range(0, 149) != 0);
      step();
    end
    $display("random phase done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
